// File: rtl/s4ga_pkg.sv
// s4ga_pkg: shared width helpers and frame-state type for the s4ga_mp LUT fabric
package s4ga_pkg;
  typedef enum logic {IDX, MASK} state_e;
  function automatic int segs(input int w, input int si_w);
    return (w + si_w - 1) / si_w;
  endfunction
  function automatic int n_w(input int n);
    return $clog2(n + 2);
  endfunction
  function automatic int idx_segs(input int n, input int si_w);
    return segs(n_w(n), si_w);
  endfunction
  function automatic int mask_segs(input int k, input int si_w);
    return segs(2 ** k, si_w);
  endfunction
  function automatic int ll(input int n, input int k, input int si_w);
    return k * idx_segs(n, si_w) + mask_segs(k, si_w);
  endfunction
endpackage

// File: rtl/s4ga_frame_ctl.sv
// s4ga_frame_ctl: tracks LUT/field/segment position of the config stream and flags field, frame and pass ends
module s4ga_frame_ctl import s4ga_pkg::*; #(
  parameter int N = 71,
  parameter int K = 5,
  parameter int SI_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 si_valid,
  input  logic                 si_sync,
  output logic [$clog2(N)-1:0] cur_n,
  output logic                 restart,
  output logic                 fld_end,
  output logic                 frm_end,
  output logic                 pass_end
);
  localparam int NB = $clog2(N);
  localparam int KB = $clog2(K + 1);
  localparam int IS = idx_segs(N, SI_W);
  localparam int MS = mask_segs(K, SI_W);
  localparam int SB = $clog2((IS > MS ? IS : MS) + 1);
  localparam logic [NB-1:0] N_LAST = NB'(N - 1);
  localparam logic [KB-1:0] K_LAST = KB'(K - 1);
  localparam logic [SB-1:0] IS_LAST = SB'(IS - 1);
  localparam logic [SB-1:0] MS_LAST = SB'(MS - 1);
  state_e st, st_d, st_e;
  logic [NB-1:0] n, n_d, n_e;
  logic [KB-1:0] k, k_d, k_e;
  logic [SB-1:0] seg, seg_d, seg_e;
  logic last_seg;
  // a sync beat is processed as if the position were already n=k=seg=0
  always_comb begin
    restart = si_valid & si_sync;
    st_e = restart ? IDX : st;
    n_e = restart ? '0 : n;
    k_e = restart ? '0 : k;
    seg_e = restart ? '0 : seg;
    last_seg = seg_e == (st_e == IDX ? IS_LAST : MS_LAST);
    fld_end = si_valid & last_seg;
    frm_end = fld_end & (st_e == MASK);
    pass_end = frm_end & (n_e == N_LAST);
    cur_n = n_e;
    st_d = st;
    n_d = n;
    k_d = k;
    seg_d = seg;
    if (si_valid) begin
      seg_d = last_seg ? '0 : seg_e + SB'(1);
      n_d = frm_end ? (pass_end ? '0 : n_e + NB'(1)) : n_e;
      k_d = frm_end ? '0 : fld_end ? k_e + KB'(1) : k_e;
      st_d = frm_end ? IDX : (fld_end && k_e == K_LAST) ? MASK : st_e;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= IDX;
      n <= '0;
      k <= '0;
      seg <= '0;
    end else begin
      st <= st_d;
      n <= n_d;
      k <= k_d;
      seg <= seg_d;
    end
endmodule

// File: rtl/s4ga_mp.sv
// s4ga_mp: serially configured K-LUT array fabric; define S4GA_HALF_LUT_EN to add the half-LUT q source
module s4ga_mp import s4ga_pkg::*; #(
  parameter int N = 71,
  parameter int K = 5,
  parameter int I = 2,
  parameter int O = 8,
  parameter int SI_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SI_W-1:0] si,
  input  logic            si_valid,
  input  logic            si_sync,
  input  logic [I-1:0]    inputs,
  output logic [O-1:0]    outputs,
  output logic            done
);
  localparam int N_W = n_w(N);
  localparam int MASK_W = 2 ** K;
  localparam int IS = idx_segs(N, SI_W);
  localparam int MS = mask_segs(K, SI_W);
  localparam int SR_W = (IS > MS ? IS : MS) * SI_W;
  localparam int NB = $clog2(N);
  logic [NB-1:0] cur_n;
  logic restart, fld_end, frm_end, pass_end, q, idx_bit, val;
  logic [N-1:0] luts, luts_d, in_ext;
  logic [K-1:0] ins;
  logic [SR_W-1:0] sr, full;
  logic [2**N_W-1:0] tbl;
  logic [MASK_W-1:0] mask;
  s4ga_frame_ctl #(.N(N), .K(K), .SI_W(SI_W)) u_ctl (
    .clk(clk),
    .rst_n(rst_n),
    .si_valid(si_valid),
    .si_sync(si_sync),
    .cur_n(cur_n),
    .restart(restart),
    .fld_end(fld_end),
    .frm_end(frm_end),
    .pass_end(pass_end)
  );
  // tbl is the whole index space: LUTs, then zeros, then q and constant 1 at the top
  always_comb begin
    full = (restart ? '0 : sr << SI_W) | SR_W'(si);
    mask = full[MASK_W-1:0];
    tbl = '0;
    tbl[N-1:0] = luts;
    tbl[2**N_W-2] = q;
    tbl[2**N_W-1] = 1'b1;
    idx_bit = tbl[full[N_W-1:0]];
    in_ext = N'(inputs);
    val = ({1'b0, cur_n} < (NB+1)'(I)) ? in_ext[cur_n] : mask[ins];
    luts_d = luts;
    luts_d[cur_n] = val;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      luts <= '0;
      ins <= '0;
      sr <= '0;
      outputs <= '0;
      done <= 1'b0;
    end else begin
      if (si_valid) sr <= fld_end ? '0 : full;
      if (fld_end && !frm_end) ins <= {ins[K-2:0], idx_bit};
      if (frm_end) luts <= luts_d;
      if (pass_end) outputs <= luts_d[N-1 -: O];
      done <= pass_end;
    end
`ifdef S4GA_HALF_LUT_EN
  always_ff @(posedge clk)
    if (!rst_n) q <= 1'b0;
    else if (frm_end) q <= mask[{1'b0, ins[K-2:0]}];
`else
  always_comb q = 1'b0;
`endif
endmodule

// File: tb/tb_s4ga_mp.sv
// tb_s4ga_mp: randomized stream bench for s4ga_mp against a per-frame behavioural model
module tb_s4ga_mp;
  localparam int N = 3, K = 2, I = 1, O = 1, SI_W = 2, LL = 6;
  typedef struct packed {
    logic [2:0] i0;
    logic [2:0] i1;
    logic [3:0] mask;
  } frame_t;
  logic clk = 1'b0, rst_n = 1'b0, si_valid = 1'b0, si_sync = 1'b0;
  logic [SI_W-1:0] si = '0;
  logic [I-1:0] inputs = '0;
  logic [O-1:0] outputs;
  logic done;
  frame_t frs [N];
  bit [N-1:0] m_luts = '0;
  bit m_q = 1'b0, stall = 1'b0, armed = 1'b0, need_sync = 1'b0;
  logic [O-1:0] nxt_out = '0, exp_out = '0;
  logic nxt_done = 1'b0, exp_done = 1'b0;
  int n_vec = 0, n_bad = 0, n_done = 0, d0;

  s4ga_mp #(.N(N), .K(K), .I(I), .O(O), .SI_W(SI_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .si(si),
    .si_valid(si_valid),
    .si_sync(si_sync),
    .inputs(inputs),
    .outputs(outputs),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_out <= nxt_out;
    exp_done <= nxt_done;
  end

  always @(negedge clk)
    if (armed) begin
      n_vec++;
      if (outputs !== exp_out) begin
        n_bad++;
        $display("FAIL outputs: got %b want %b at %0t", outputs, exp_out, $time);
      end
      n_vec++;
      if (done !== exp_done) begin
        n_bad++;
        $display("FAIL done: got %b want %b at %0t", done, exp_done, $time);
      end
      if (done === 1'b1) n_done++;
    end

  task automatic chk(input string name, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic bit look(input logic [2:0] x);
    if (x < 3'(N)) return m_luts[x];
    if (x == 3'd7) return 1'b1;
    if (x == 3'd6) return m_q;
    return 1'b0;
  endfunction

  // one frame of the sequential evaluation: decode both fields, then write the LUT
  function automatic void step(input int n, input bit inp);
    logic [1:0] ins_v;
    bit v;
    ins_v = {look(frs[n].i0), look(frs[n].i1)};
    v = (n < I) ? inp : frs[n].mask[ins_v];
`ifdef S4GA_HALF_LUT_EN
    m_q = frs[n].mask[{1'b0, ins_v[0]}];
`endif
    m_luts[n] = v;
  endfunction

  task automatic idle();
    @(negedge clk); #1;
    rst_n = 1'b1;
    si_valid = 1'b0;
    si = 2'($urandom);
    si_sync = 1'($urandom);
    nxt_done = 1'b0;
  endtask

  task automatic beat(input logic [1:0] d, input bit sync, input bit fin, input bit inp);
    if (stall) while ($urandom_range(0, 1) == 1) idle();
    @(negedge clk); #1;
    rst_n = 1'b1;
    si_valid = 1'b1;
    si = d;
    si_sync = sync;
    inputs = inp;
    nxt_done = fin;
    if (fin) for (int j = 0; j < O; j++) nxt_out[j] = m_luts[N-O+j];
  endtask

  task automatic do_reset(input int c);
    for (int j = 0; j < c; j++) begin
      @(negedge clk); #1;
      rst_n = 1'b0;
      si_valid = 1'b1;
      si = 2'($urandom);
      si_sync = 1'($urandom);
      nxt_out = '0;
      nxt_done = 1'b0;
      if (j == 1) armed = 1'b1;
    end
    m_luts = '0;
    m_q = 1'b0;
    need_sync = 1'b0;
  endtask

  // cut>0 stops the pass after that many beats, leaving the DUT mid-pass
  task automatic send_pass(input bit inp, input int cut, input bit sync0);
    logic [1:0] bts[$];
    logic [3:0] w;
    int total;
    bts = {};
    for (int n = 0; n < N; n++) begin
      w = {1'($urandom), frs[n].i0};
      bts.push_back(w[3:2]);
      bts.push_back(w[1:0]);
      w = {1'($urandom), frs[n].i1};
      bts.push_back(w[3:2]);
      bts.push_back(w[1:0]);
      w = frs[n].mask;
      bts.push_back(w[3:2]);
      bts.push_back(w[1:0]);
    end
    total = cut > 0 ? cut : N * LL;
    for (int n = 0; n < N; n++) if ((n + 1) * LL <= total) step(n, inp);
    for (int b = 0; b < total; b++)
      beat(bts[b], b == 0 ? (sync0 | need_sync) : 1'b0, cut == 0 && b == total - 1, inp);
    need_sync = cut > 0;
  endtask

  task automatic std_frames();
    frs[0] = frame_t'($urandom);
    frs[1] = '{i0: 3'd0, i1: 3'd7, mask: 4'h2};
    frs[2] = '{i0: 3'd1, i1: 3'd7, mask: 4'h2};
  endtask

  task automatic rand_frames();
    for (int n = 0; n < N; n++) frs[n] = frame_t'($urandom);
  endtask

  initial begin
    for (int n = 0; n < N; n++) frs[n] = '0;
    do_reset(3);
    send_pass(1'b0, 0, 1'b0);
    idle();
    chk("reset_pass_out", int'(outputs), 0);
    std_frames();
    send_pass(1'b1, 0, 1'($urandom));
    idle();
    chk("basic_in1", int'(outputs), 1);
    send_pass(1'b0, 0, 1'($urandom));
    idle();
    chk("basic_in0", int'(outputs), 0);
    stall = 1'b1;
    send_pass(1'b1, 0, 1'($urandom));
    idle();
    chk("stall_in1", int'(outputs), 1);
    send_pass(1'b0, 0, 1'($urandom));
    idle();
    chk("stall_in0", int'(outputs), 0);
    stall = 1'b0;
    d0 = n_done;
    rand_frames();
    send_pass(1'($urandom), 7, 1'b0);
    std_frames();
    send_pass(1'b1, 0, 1'b1);
    idle();
    chk("resync_out", int'(outputs), 1);
    chk("resync_done_count", n_done - d0, 1);
    for (int p = 0; p < 2; p++) begin
      frs[0] = frame_t'($urandom);
      frs[1] = '{i0: 3'd7, i1: 3'd0, mask: 4'b1010};
      frs[2] = '{i0: 3'd6, i1: 3'd7, mask: 4'h8};
      send_pass(1'(p), 0, 1'b0);
      idle();
`ifdef S4GA_HALF_LUT_EN
      chk("half_lut", int'(outputs), p);
`else
      chk("half_lut", int'(outputs), 0);
`endif
    end
    for (int p = 0; p < 2; p++) begin
      std_frames();
      frs[2] = '{i0: 3'd5, i1: 3'd7, mask: 4'h2};
      send_pass(1'(p), 0, 1'b0);
      idle();
      chk("oor_idx", int'(outputs), 1);
    end
    for (int p = 0; p < 40; p++) begin
      rand_frames();
      stall = 1'($urandom);
      send_pass(1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N * LL - 1)) : 0,
                1'($urandom));
    end
    stall = 1'b0;
    std_frames();
    send_pass(1'b1, 0, 1'b0);
    idle();
    chk("final_in1", int'(outputs), 1);
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
